// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Producer-side hazard tracker for the ID stage of a 5-stage pipeline. Every
// accepted register write is recorded with the number of cycles left before
// its value reaches a forwarding path (ALU: now, LOAD: 1, LONG: LONG_LAT).
// stall_ID is raised while an ID source operand is still counting down, or
// while a LONG op wants to issue and the single long unit is busy. The EX
// forwarding mux therefore only ever sees dependencies it can satisfy.
//
// Parameters
//   NREG      architectural register count (x0 never tracked)
//   LONG_LAT  mul/div issue-to-forwardable latency, 1..15
//
// Ports
//   clk, rst_n               clock, synchronous active-low reset
//   raddr1_ID/raddr2_ID      ID source registers
//   RS1Use_ID/RS2Use_ID      source actually read
//   issue_valid              ID instruction valid
//   issue_rd/issue_RegWrite  destination register / writes rd
//   issue_class              0=ALU 1=LOAD 2=LONG 3=reserved(ALU)
//   flush_ID                 kill the ID instruction (no issue)
//   flush_EX                 kill the instruction issued last cycle
//   wb_valid/wb_waddr        WB commit
//   stall_ID                 hold PC/IF/ID, bubble into EX
//   long_busy                a LONG op is outstanding
//   pending                  per-register busy vector (bit 0 always 0)
//
// Optional build macro SCOREBOARD_STATS_EN adds the wrapping counters
//   stall_cycles    cycles with stall_ID=1
//   loaduse_stalls  stall cycles caused solely by LOAD-class entries
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter int NREG     = 32,
  parameter int LONG_LAT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      raddr1_ID,
  input  logic [4:0]      raddr2_ID,
  input  logic            RS1Use_ID,
  input  logic            RS2Use_ID,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  input  logic            issue_RegWrite,
  input  logic [1:0]      issue_class,
  input  logic            flush_ID,
  input  logic            flush_EX,
  input  logic            wb_valid,
  input  logic [4:0]      wb_waddr,
  output logic            stall_ID,
  output logic            long_busy,
  output logic [NREG-1:0] pending
`ifdef SCOREBOARD_STATS_EN
  ,
  output logic [31:0]     stall_cycles,
  output logic [31:0]     loaduse_stalls
`endif
);

  typedef enum logic [1:0] {
    CLS_ALU  = 2'd0,
    CLS_LOAD = 2'd1,
    CLS_LONG = 2'd2,
    CLS_RSVD = 2'd3
  } iclass_e;

  localparam logic [3:0] LONG_CNT = 4'(LONG_LAT);

  logic [NREG-1:0] busy_q, busy_d;
  logic [3:0]      cnt_q [NREG];
  logic [3:0]      cnt_d [NREG];
  logic [4:0]      ex_rd_q, ex_rd_d;
  logic            ex_vld_q, ex_vld_d;
  logic            ex_long_q, ex_long_d;   // flushed op was LONG -> drop lcnt
  logic [3:0]      lcnt_q, lcnt_d;

  iclass_e    cls;
  logic       rs1_hit, rs2_hit, long_hit;
  logic       issue_write;
  logic [3:0] issue_cnt;

  assign cls = iclass_e'(issue_class);

  // A source only stalls while its producer is still counting down; once the
  // count reaches zero the value is on a forwarding path.
  assign rs1_hit  = RS1Use_ID && (raddr1_ID != '0) && busy_q[raddr1_ID] && (cnt_q[raddr1_ID] != '0);
  assign rs2_hit  = RS2Use_ID && (raddr2_ID != '0) && busy_q[raddr2_ID] && (cnt_q[raddr2_ID] != '0);
  assign long_hit = issue_valid && (cls == CLS_LONG) && long_busy;
  assign stall_ID = rs1_hit || rs2_hit || long_hit;

  assign long_busy = (lcnt_q != '0);
  assign pending   = {busy_q[NREG-1:1], 1'b0};

  assign issue_write = issue_valid && !stall_ID && !flush_ID && issue_RegWrite && (issue_rd != '0);

  always_comb begin
    unique case (cls)
      CLS_LOAD: issue_cnt = 4'd1;
      CLS_LONG: issue_cnt = LONG_CNT;
      default:  issue_cnt = 4'd0;
    endcase
  end

  // Events are applied lowest priority first so later writes win:
  // countdown, WB commit, EX flush, then the new issue.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    lcnt_d    = lcnt_q;
    ex_rd_d   = ex_rd_q;
    ex_vld_d  = 1'b0;
    ex_long_d = 1'b0;

    for (int r = 0; r < NREG; r++) begin
      if (cnt_q[r] != '0) cnt_d[r] = cnt_q[r] - 4'd1;
    end
    if (lcnt_q != '0) lcnt_d = lcnt_q - 4'd1;

    if (wb_valid && (wb_waddr != '0)) begin
      busy_d[wb_waddr] = 1'b0;
      cnt_d[wb_waddr]  = '0;
    end

    if (flush_EX && ex_vld_q) begin
      busy_d[ex_rd_q] = 1'b0;
      cnt_d[ex_rd_q]  = '0;
      if (ex_long_q) lcnt_d = '0;
    end

    if (issue_write) begin
      busy_d[issue_rd] = 1'b1;
      cnt_d[issue_rd]  = issue_cnt;
      ex_rd_d          = issue_rd;
      ex_vld_d         = 1'b1;
      ex_long_d        = (cls == CLS_LONG);
      if (cls == CLS_LONG) lcnt_d = LONG_CNT;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the count array is reset too: a stale nonzero count behind a
    // cleared busy bit would resurface on the next issue-less WAW check.
    if (!rst_n) begin
      busy_q    <= '0;
      cnt_q     <= '{default: '0};
      ex_rd_q   <= '0;
      ex_vld_q  <= 1'b0;
      ex_long_q <= 1'b0;
      lcnt_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so all state updates see pre-edge values.
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      ex_rd_q   <= ex_rd_d;
      ex_vld_q  <= ex_vld_d;
      ex_long_q <= ex_long_d;
      lcnt_q    <= lcnt_d;
    end
  end

`ifdef SCOREBOARD_STATS_EN
  logic [NREG-1:0] is_load_q;
  logic [31:0]     stall_cycles_q, loaduse_stalls_q;
  logic            load_only;

  // Every stalling source must be a LOAD producer and no structural stall.
  assign load_only = stall_ID && !long_hit &&
                     (!rs1_hit || is_load_q[raddr1_ID]) &&
                     (!rs2_hit || is_load_q[raddr2_ID]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      is_load_q        <= '0;
      stall_cycles_q   <= '0;
      loaduse_stalls_q <= '0;
    end else begin
      if (issue_write) is_load_q[issue_rd] <= (cls == CLS_LOAD);
      if (stall_ID)    stall_cycles_q      <= stall_cycles_q + 32'd1;
      if (load_only)   loaduse_stalls_q    <= loaduse_stalls_q + 32'd1;
    end
  end

  assign stall_cycles   = stall_cycles_q;
  assign loaduse_stalls = loaduse_stalls_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
//
// Directed bench for hazard_scoreboard (NREG=32, LONG_LAT=4). Inputs change
// 1 time unit after each rising edge; outputs are sampled 1 unit later still.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;

  localparam int NREG = 32;
  localparam int LAT  = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [4:0]      raddr1_ID, raddr2_ID;
  logic            RS1Use_ID, RS2Use_ID;
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic            issue_RegWrite;
  logic [1:0]      issue_class;
  logic            flush_ID, flush_EX;
  logic            wb_valid;
  logic [4:0]      wb_waddr;
  logic            stall_ID, long_busy;
  logic [NREG-1:0] pending;
`ifdef SCOREBOARD_STATS_EN
  logic [31:0]     stall_cycles, loaduse_stalls;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.NREG(NREG), .LONG_LAT(LAT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .raddr1_ID      (raddr1_ID),
    .raddr2_ID      (raddr2_ID),
    .RS1Use_ID      (RS1Use_ID),
    .RS2Use_ID      (RS2Use_ID),
    .issue_valid    (issue_valid),
    .issue_rd       (issue_rd),
    .issue_RegWrite (issue_RegWrite),
    .issue_class    (issue_class),
    .flush_ID       (flush_ID),
    .flush_EX       (flush_EX),
    .wb_valid       (wb_valid),
    .wb_waddr       (wb_waddr),
    .stall_ID       (stall_ID),
    .long_busy      (long_busy),
    .pending        (pending)
`ifdef SCOREBOARD_STATS_EN
    ,
    .stall_cycles   (stall_cycles),
    .loaduse_stalls (loaduse_stalls)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs may be changed right after, outputs sampled #1 later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    raddr1_ID = '0; raddr2_ID = '0; RS1Use_ID = 1'b0; RS2Use_ID = 1'b0;
    issue_valid = 1'b0; issue_rd = '0; issue_RegWrite = 1'b0; issue_class = 2'd0;
    flush_ID = 1'b0; flush_EX = 1'b0; wb_valid = 1'b0; wb_waddr = '0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [1:0] cls);
    issue_valid = 1'b1; issue_rd = rd; issue_RegWrite = 1'b1; issue_class = cls;
  endtask

  task automatic no_issue();
    issue_valid = 1'b0; issue_RegWrite = 1'b0;
  endtask

  task automatic commit(input logic [4:0] rd);
    wb_valid = 1'b1; wb_waddr = rd;
    tick();
    wb_valid = 1'b0;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    settle();
    check("reset_stall", 32'(stall_ID), 32'd0);
    check("reset_long_busy", 32'(long_busy), 32'd0);
    check("reset_pending", pending, 32'd0);

    // ALU producer rd=5: dependent reader never stalls; busy until WB.
    issue(5'd5, 2'd0);
    settle();
    check("alu_issue_stall", 32'(stall_ID), 32'd0);
    tick();
    no_issue(); RS1Use_ID = 1'b1; raddr1_ID = 5'd5;
    settle();
    check("alu_dep_stall", 32'(stall_ID), 32'd0);
    check("alu_pending5", 32'(pending[5]), 32'd1);
    tick();
    check("alu_pending5_hold", 32'(pending[5]), 32'd1);
    commit(5'd5);
    settle();
    check("alu_pending5_wb", 32'(pending[5]), 32'd0);
    idle();

    // LOAD rd=7, rs2 reader: one load-use stall cycle.
    issue(5'd7, 2'd1);
    tick();
    no_issue(); RS2Use_ID = 1'b1; raddr2_ID = 5'd7;
    settle();
    check("load_use_stall", 32'(stall_ID), 32'd1);
    tick();
    check("load_use_release", 32'(stall_ID), 32'd0);
    // Same again with RS2Use_ID=0: no stall though rd=7 is counting down.
    RS2Use_ID = 1'b0;
    issue(5'd7, 2'd1);
    tick();
    no_issue();
    settle();
    check("load_nouse_stall", 32'(stall_ID), 32'd0);
    check("load_nouse_pending7", 32'(pending[7]), 32'd1);
    commit(5'd7);
    idle();

    // LONG rd=9, rs1 reader: LONG_LAT stall cycles.
    issue(5'd9, 2'd2);
    tick();
    no_issue(); RS1Use_ID = 1'b1; raddr1_ID = 5'd9;
    settle();
    check("long_busy_set", 32'(long_busy), 32'd1);
    for (int i = 0; i < LAT; i++) begin
      check($sformatf("long_dep_stall_%0d", i), 32'(stall_ID), 32'd1);
      tick();
    end
    check("long_dep_release", 32'(stall_ID), 32'd0);
    check("long_busy_clear", 32'(long_busy), 32'd0);
    idle();

    // LONG rd=10 then a second LONG rd=11 waits for the unit.
    issue(5'd10, 2'd2);
    tick();
    issue(5'd11, 2'd2);
    settle();
    for (int i = 0; i < LAT; i++) begin
      check($sformatf("long2_stall_%0d", i), 32'(stall_ID), 32'd1);
      check($sformatf("long2_not_issued_%0d", i), 32'(pending[11]), 32'd0);
      tick();
    end
    check("long2_release", 32'(stall_ID), 32'd0);
    tick();
    no_issue();
    settle();
    check("long2_pending11", 32'(pending[11]), 32'd1);
    check("long2_busy", 32'(long_busy), 32'd1);
    for (int i = 0; i < LAT; i++) tick();
    commit(5'd9); commit(5'd10); commit(5'd11);
    idle();

    // flush_ID suppresses an issue.
    issue(5'd6, 2'd1); flush_ID = 1'b1;
    tick();
    no_issue(); flush_ID = 1'b0;
    settle();
    check("flush_id_pending6", 32'(pending[6]), 32'd0);

    // LOAD rd=3 in n, flush_EX in n+1: reader sees no stall from n+2.
    issue(5'd3, 2'd1);
    tick();
    no_issue(); flush_EX = 1'b1; RS1Use_ID = 1'b1; raddr1_ID = 5'd3;
    settle();
    check("flush_ex_stall_same_cycle", 32'(stall_ID), 32'd1);
    tick();
    flush_EX = 1'b0;
    settle();
    check("flush_ex_pending3", 32'(pending[3]), 32'd0);
    check("flush_ex_no_stall", 32'(stall_ID), 32'd0);
    idle();

    // Flushing a LONG also frees the long unit.
    issue(5'd12, 2'd2);
    tick();
    no_issue(); flush_EX = 1'b1;
    settle();
    check("flush_long_busy_before", 32'(long_busy), 32'd1);
    tick();
    flush_EX = 1'b0;
    settle();
    check("flush_long_busy_after", 32'(long_busy), 32'd0);
    check("flush_long_pending12", 32'(pending[12]), 32'd0);

    // WAW: WB commit rd=4 and LOAD issue rd=4 in the same cycle.
    issue(5'd4, 2'd0);
    tick();
    issue(5'd4, 2'd1); wb_valid = 1'b1; wb_waddr = 5'd4;
    tick();
    no_issue(); wb_valid = 1'b0; RS1Use_ID = 1'b1; raddr1_ID = 5'd4;
    settle();
    check("waw_pending4", 32'(pending[4]), 32'd1);
    check("waw_stall", 32'(stall_ID), 32'd1);
    tick();
    check("waw_release", 32'(stall_ID), 32'd0);
    check("waw_pending4_hold", 32'(pending[4]), 32'd1);
    commit(5'd4);
    idle();

    // x0 is never tracked.
    issue(5'd0, 2'd1);
    tick();
    no_issue(); RS1Use_ID = 1'b1; raddr1_ID = 5'd0;
    settle();
    check("x0_stall", 32'(stall_ID), 32'd0);
    check("x0_pending_all", pending, 32'd0);
    idle();

    // Reset in the middle of a LONG discards everything in one cycle.
    issue(5'd13, 2'd2);
    tick();
    no_issue(); RS1Use_ID = 1'b1; raddr1_ID = 5'd13;
    settle();
    check("midrst_stall_before", 32'(stall_ID), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    settle();
    check("midrst_stall_after", 32'(stall_ID), 32'd0);
    check("midrst_long_busy_after", 32'(long_busy), 32'd0);
    check("midrst_pending_after", pending, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
